// File: rtl/multiplier_arbiter.sv
// Round-robin front end that shares one sequential 4x4 multiplier among NUM_REQ clients.
// Grant is registered at the arbitration edge; mul_start follows one cycle later.
// Requests are only sampled in IDLE, so clients hold req until granted and see no backpressure otherwise.
module multiplier_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 31
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   req_multiplier,
    input  logic [4*NUM_REQ-1:0]   req_multiplicand,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic                   resp_err,
    output logic [7:0]             resp_product,
    output logic                   busy,
    output logic                   mul_start,
    output logic [3:0]             mul_multiplier,
    output logic [3:0]             mul_multiplicand,
    output logic                   mul_rst,
    input  logic [7:0]             mul_product,
    input  logic                   mul_done
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] sel;
    logic          found;
    logic [7:0]    wd_cnt;
    logic          err_flag;
    logic          done_prev;
    logic          done_rise;
    int            scan_idx;

    // A level left high by the previous operation must not complete the next one.
    assign done_rise = mul_done & ~done_prev;

    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                sel   = PW'(scan_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            owner            <= '0;
            wd_cnt           <= '0;
            err_flag         <= 1'b0;
            done_prev        <= 1'b0;
            grant            <= '0;
            resp_valid       <= '0;
            resp_err         <= 1'b0;
            resp_product     <= '0;
            busy             <= 1'b0;
            mul_start        <= 1'b0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
            mul_rst          <= 1'b0;
        end else begin
            done_prev  <= mul_done;
            grant      <= '0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            mul_start  <= 1'b0;
            mul_rst    <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant[sel]       <= 1'b1;
                        owner            <= sel;
                        rr_ptr           <= (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                        mul_multiplier   <= req_multiplier[4*sel +: 4];
                        mul_multiplicand <= req_multiplicand[4*sel +: 4];
                        busy             <= 1'b1;
                        state            <= START;
                    end
                end
                START: begin
                    mul_start <= 1'b1;
                    wd_cnt    <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + 8'd1;
                    if (done_rise) begin
                        resp_product <= mul_product;
                        state        <= RESP;
                    end else if (wd_cnt == 8'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th WAIT cycle with no completion: abort the multiplier.
                        mul_rst      <= 1'b1;
                        resp_product <= 8'h00;
                        err_flag     <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    resp_valid[owner] <= 1'b1;
                    resp_err          <= err_flag;
                    err_flag          <= 1'b0;
                    busy              <= 1'b0;
                    state             <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multiplier_arbiter.sv
// Bench for multiplier_arbiter: behavioural multiplier model plus grant/response scoreboards.
module tb_multiplier_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 31;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [4*NUM_REQ-1:0] req_multiplier;
    logic [4*NUM_REQ-1:0] req_multiplicand;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   resp_valid;
    logic                 resp_err;
    logic [7:0]           resp_product;
    logic                 busy;
    logic                 mul_start;
    logic [3:0]           mul_multiplier;
    logic [3:0]           mul_multiplicand;
    logic                 mul_rst;
    logic [7:0]           mul_product;
    logic                 mul_done;

    multiplier_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .req_multiplier   (req_multiplier),
        .req_multiplicand (req_multiplicand),
        .grant            (grant),
        .resp_valid       (resp_valid),
        .resp_err         (resp_err),
        .resp_product     (resp_product),
        .busy             (busy),
        .mul_start        (mul_start),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_rst          (mul_rst),
        .mul_product      (mul_product),
        .mul_done         (mul_done)
    );

    typedef struct {
        int       idx;
        logic [3:0] a;
        logic [3:0] b;
    } gnt_t;

    typedef struct {
        int         idx;
        logic [7:0] prod;
        logic       err;
        int         lat;
    } resp_t;

    gnt_t  exp_gnt[$];
    resp_t exp_resp[$];

    int n_checks = 0;
    int n_fail   = 0;
    int neg_cnt  = 0;
    int grant_at = 0;
    int start_at = 0;
    int start_count = 0;
    int rst_count   = 0;

    int mul_delay  = 6;
    bit hold_done  = 0;
    bit never_done = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Multiplier model: product/done appear mul_delay cycles after the start pulse.
    initial begin
        int         mcnt;
        bit         m_busy;
        logic [3:0] ma, mb;
        mcnt = 0; m_busy = 0; ma = '0; mb = '0;
        mul_done = 1'b0;
        mul_product = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_busy = 0;
                mul_done = 1'b0;
            end else if (mul_rst) begin
                m_busy = 0;
            end else if (mul_start) begin
                m_busy = 1; mcnt = 0; ma = mul_multiplier; mb = mul_multiplicand;
                if (!hold_done) mul_done = 1'b0;
            end else if (m_busy && !never_done) begin
                mcnt++;
                if (hold_done && mcnt == mul_delay - 1) mul_done = 1'b0;
                if (mcnt == mul_delay) begin
                    mul_product = {4'b0, ma} * {4'b0, mb};
                    mul_done = 1'b1;
                    m_busy = 0;
                end
            end
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        gnt_t       g;
        resp_t      r;
        logic [3:0] oh;
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (rst) begin
                if (grant !== '0) begin
                    n_checks++;
                    if (exp_gnt.size() == 0) begin
                        n_fail++;
                        $display("FAIL grant_unexpected: got %b, required no grant", grant);
                    end else begin
                        g = exp_gnt.pop_front();
                        oh = 4'b0001 << g.idx;
                        if (grant !== oh || mul_multiplier !== g.a || mul_multiplicand !== g.b) begin
                            n_fail++;
                            $display("FAIL grant: got %b A=%0d B=%0d, required %b A=%0d B=%0d",
                                     grant, mul_multiplier, mul_multiplicand, oh, g.a, g.b);
                        end
                    end
                    grant_at = neg_cnt;
                end
                if (mul_start === 1'b1) begin
                    n_checks++;
                    if (neg_cnt - grant_at !== 1) begin
                        n_fail++;
                        $display("FAIL start_latency: got %0d, required 1", neg_cnt - grant_at);
                    end
                    start_at = neg_cnt;
                    start_count++;
                end
                if (mul_rst === 1'b1) begin
                    n_checks++;
                    if (neg_cnt - start_at !== TIMEOUT) begin
                        n_fail++;
                        $display("FAIL abort_latency: got %0d, required %0d", neg_cnt - start_at, TIMEOUT);
                    end
                    rst_count++;
                end
                if (resp_valid !== '0) begin
                    n_checks++;
                    if (exp_resp.size() == 0) begin
                        n_fail++;
                        $display("FAIL resp_unexpected: got %b, required no response", resp_valid);
                    end else begin
                        r = exp_resp.pop_front();
                        oh = 4'b0001 << r.idx;
                        if (resp_valid !== oh || resp_product !== r.prod || resp_err !== r.err
                            || neg_cnt - start_at !== r.lat) begin
                            n_fail++;
                            $display("FAIL resp: got valid=%b prod=%0d err=%b lat=%0d, required valid=%b prod=%0d err=%b lat=%0d",
                                     resp_valid, resp_product, resp_err, neg_cnt - start_at,
                                     oh, r.prod, r.err, r.lat);
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        req = '0;
        rst = 1'b0;
        exp_gnt.delete();
        exp_resp.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_multiplier[4*i +: 4]   = a;
        req_multiplicand[4*i +: 4] = b;
    endtask

    task automatic expect_op(input int i, input logic [3:0] a, input logic [3:0] b);
        gnt_t  g;
        resp_t r;
        g.idx = i; g.a = a; g.b = b;
        r.idx = i; r.prod = {4'b0, a} * {4'b0, b}; r.err = 1'b0; r.lat = mul_delay + 2;
        exp_gnt.push_back(g);
        exp_resp.push_back(r);
    endtask

    // Raise the requested bits; each requester drops its req on seeing its grant.
    task automatic serve(input logic [NUM_REQ-1:0] mask);
        req = req | mask;
        for (int c = 0; c < 400 && req != '0; c++) begin
            @(negedge clk);
            req = req & ~grant;
        end
        n_checks++;
        if (req != '0) begin
            n_fail++;
            $display("FAIL serve_timeout: req still %b, required all granted", req);
            req = '0;
        end
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (c < 400 && (exp_resp.size() != 0 || busy !== 1'b0)) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (exp_resp.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d responses outstanding busy=%b, required 0 and 0",
                     name, exp_resp.size(), busy);
            exp_resp.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = '0;
        req_multiplier = '0;
        req_multiplicand = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (grant !== '0 || resp_valid !== '0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: got grant=%b valid=%b err=%b, required 0", grant, resp_valid, resp_err);
        end
        n_checks++;
        if (resp_product !== 8'h00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got prod=%0d busy=%b, required 0", resp_product, busy);
        end
        n_checks++;
        if (mul_start !== 1'b0 || mul_rst !== 1'b0 || mul_multiplier !== '0 || mul_multiplicand !== '0) begin
            n_fail++;
            $display("FAIL reset_mul_if: got start=%b rst=%b A=%0d B=%0d, required 0",
                     mul_start, mul_rst, mul_multiplier, mul_multiplicand);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || grant !== '0) begin
            n_fail++;
            $display("FAIL idle_no_req: got busy=%b grant=%b, required 0", busy, grant);
        end
    endtask

    task automatic test_single();
        int s0;
        do_reset();
        mul_delay = 6;
        s0 = start_count;
        set_op(0, 4'd3, 4'd5);
        expect_op(0, 4'd3, 4'd5);
        serve(4'b0001);
        wait_idle("single");
        n_checks++;
        if (start_count - s0 !== 1) begin
            n_fail++;
            $display("FAIL single_start_count: got %0d, required 1", start_count - s0);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (resp_product !== 8'd15) begin
            n_fail++;
            $display("FAIL product_hold: got %0d, required 15", resp_product);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        mul_delay = 3;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_op(i, 4'(i + 2), 4'(i + 7));
            expect_op(i, 4'(i + 2), 4'(i + 7));
        end
        serve(4'b1111);
        wait_idle("rr_burst1");
        for (int i = 0; i < NUM_REQ; i++) begin
            set_op(i, 4'(i + 9), 4'(15 - i));
            expect_op(i, 4'(i + 9), 4'(15 - i));
        end
        serve(4'b1111);
        wait_idle("rr_burst2");
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        mul_delay = 2;
        set_op(1, 4'd1, 4'd1);
        expect_op(1, 4'd1, 4'd1);
        serve(4'b0010);
        wait_idle("ptr_setup");
        set_op(3, 4'd15, 4'd15);
        set_op(0, 4'd2, 4'd3);
        set_op(1, 4'd4, 4'd4);
        expect_op(3, 4'd15, 4'd15);
        expect_op(0, 4'd2, 4'd3);
        expect_op(1, 4'd4, 4'd4);
        serve(4'b1011);
        wait_idle("ptr_wrap");
    endtask

    task automatic test_done_held();
        do_reset();
        mul_delay = 4;
        set_op(0, 4'd6, 4'd7);
        expect_op(0, 4'd6, 4'd7);
        serve(4'b0001);
        wait_idle("held_first");
        hold_done = 1;
        set_op(1, 4'd9, 4'd9);
        expect_op(1, 4'd9, 4'd9);
        serve(4'b0010);
        wait_idle("held_second");
        hold_done = 0;
    endtask

    task automatic test_timeout();
        resp_t r;
        gnt_t  g;
        int    r0;
        do_reset();
        mul_delay = 3;
        set_op(0, 4'd2, 4'd9);
        expect_op(0, 4'd2, 4'd9);
        serve(4'b0001);
        wait_idle("to_first");
        never_done = 1;
        r0 = rst_count;
        set_op(1, 4'd5, 4'd5);
        g.idx = 1; g.a = 4'd5; g.b = 4'd5;
        r.idx = 1; r.prod = 8'h00; r.err = 1'b1; r.lat = TIMEOUT + 1;
        exp_gnt.push_back(g);
        exp_resp.push_back(r);
        serve(4'b0010);
        wait_idle("timeout");
        never_done = 0;
        n_checks++;
        if (rst_count - r0 !== 1) begin
            n_fail++;
            $display("FAIL abort_pulse_count: got %0d, required 1", rst_count - r0);
        end
    endtask

    task automatic test_reset_mid();
        gnt_t g;
        int   s0;
        int   c;
        do_reset();
        mul_delay = 20;
        s0 = start_count;
        set_op(0, 4'd7, 4'd7);
        g.idx = 0; g.a = 4'd7; g.b = 4'd7;
        exp_gnt.push_back(g);
        serve(4'b0001);
        c = 0;
        while (c < 50 && start_count == s0) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: got %b, required 1", busy);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({grant, resp_valid, resp_err, resp_product, busy, mul_start, mul_rst,
             mul_multiplier, mul_multiplicand} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b prod=%0d A=%0d B=%0d, required all zero",
                     busy, resp_product, mul_multiplier, mul_multiplicand);
        end
        exp_gnt.delete();
        exp_resp.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        mul_delay = 5;
        set_op(2, 4'd4, 4'd13);
        expect_op(2, 4'd4, 4'd13);
        serve(4'b0100);
        wait_idle("after_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_done_held();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_gnt.size() != 0) begin
            n_fail++;
            $display("FAIL grants_outstanding: got %0d, required 0", exp_gnt.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
